// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl -- APB3 GPIO controller for an array of bidirectional pad cells.
//
// Drives pad D/E per pin from the DATA_OUT/OE registers. Samples pad Y through
// a two-flop synchroniser plus a history flop. Per-pin rising/falling edges are
// latched into STATUS (write-1-to-clear). IRQ is the OR of STATUS.
//
// Ports:
//   PCLK, PRESETN              clock, synchronous active-low reset
//   PSEL/PENABLE/PWRITE        APB3 control
//   PADDR[7:0], PWDATA[31:0]   APB address (bits [1:0] ignored) / write data
//   PRDATA[31:0]               read data, combinational, 0 outside read access
//   PREADY, PSLVERR            always ready; error on unmapped address
//   GPIO_D, GPIO_E             to pad cells (E=1 drives the pin)
//   GPIO_Y                     from pad cells, asynchronous to PCLK
//   IRQ                        level interrupt, active-high
//
// Map: 0x00 DATA_OUT, 0x04 OE, 0x08 DATA_IN (RO), 0x0C RISE_EN, 0x10 FALL_EN,
//      0x14 STATUS (W1C). Anything above 0x14 is unmapped.
module gpio_pad_ctrl #(
  parameter int          NUM_PINS   = 8,
  parameter logic [31:0] DOUT_RESET = 32'd0,
  parameter logic [31:0] OE_RESET   = 32'd0
) (
  input  logic                PCLK,
  input  logic                PRESETN,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [7:0]          PADDR,
  input  logic [31:0]         PWDATA,
  output logic [31:0]         PRDATA,
  output logic                PREADY,
  output logic                PSLVERR,
  output logic [NUM_PINS-1:0] GPIO_D,
  output logic [NUM_PINS-1:0] GPIO_E,
  input  logic [NUM_PINS-1:0] GPIO_Y,
  output logic                IRQ
);

  localparam logic [5:0] A_DOUT = 6'd0;
  localparam logic [5:0] A_OE   = 6'd1;
  localparam logic [5:0] A_DIN  = 6'd2;
  localparam logic [5:0] A_REN  = 6'd3;
  localparam logic [5:0] A_FEN  = 6'd4;
  localparam logic [5:0] A_STAT = 6'd5;

  logic [NUM_PINS-1:0] data_out, oe, rise_en, fall_en, status;
  logic [NUM_PINS-1:0] s1, s2, s3;
  logic [NUM_PINS-1:0] rise, fall, clr, rsel;
  logic [1:0]          arm_cnt;
  logic                armed;
  logic                acc, wr_acc, rd_acc, mapped;
  logic [5:0]          word;
  logic                unused_bits;

  assign word   = PADDR[7:2];
  assign acc    = PSEL & PENABLE;
  assign wr_acc = acc & PWRITE;
  assign rd_acc = acc & ~PWRITE;
  assign mapped = (word <= A_STAT);

  // Byte-lane bits and write-data bits above NUM_PINS carry no state.
  assign unused_bits = ^{PADDR[1:0], PWDATA};

  // Edge detection stays off until the synchroniser has flushed the reset
  // zeros, so pins held high through reset do not look like rising edges.
  assign armed = (arm_cnt == 2'd3);
  assign rise  = s2 & ~s3 & rise_en & {NUM_PINS{armed}};
  assign fall  = ~s2 & s3 & fall_en & {NUM_PINS{armed}};
  assign clr   = {NUM_PINS{wr_acc && (word == A_STAT)}} & PWDATA[NUM_PINS-1:0];

  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      data_out <= DOUT_RESET[NUM_PINS-1:0];
      oe       <= OE_RESET[NUM_PINS-1:0];
      rise_en  <= '0;
      fall_en  <= '0;
      status   <= '0;
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      arm_cnt  <= 2'd0;
    end else begin
      s1 <= GPIO_Y;
      s2 <= s1;
      s3 <= s2;
      if (!armed) arm_cnt <= arm_cnt + 2'd1;
      // A new edge beats a simultaneous W1C so no event is lost.
      status <= (status & ~clr) | rise | fall;
      if (wr_acc) begin
        case (word)
          A_DOUT:  data_out <= PWDATA[NUM_PINS-1:0];
          A_OE:    oe       <= PWDATA[NUM_PINS-1:0];
          A_REN:   rise_en  <= PWDATA[NUM_PINS-1:0];
          A_FEN:   fall_en  <= PWDATA[NUM_PINS-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rsel = '0;
    case (word)
      A_DOUT:  rsel = data_out;
      A_OE:    rsel = oe;
      A_DIN:   rsel = s2;
      A_REN:   rsel = rise_en;
      A_FEN:   rsel = fall_en;
      A_STAT:  rsel = status;
      default: rsel = '0;
    endcase
  end

  // Bus outputs are held quiet while reset is asserted.
  assign PRDATA  = (rd_acc && PRESETN) ? 32'(rsel) : 32'd0;
  assign PSLVERR = acc & ~mapped & PRESETN;
  assign PREADY  = 1'b1;
  assign GPIO_D  = data_out;
  assign GPIO_E  = oe;
  assign IRQ     = |status;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Scoreboard bench for gpio_pad_ctrl: stimulus queues expected APB responses,
// a negedge monitor pops and compares on every access phase.
module tb_gpio_pad_ctrl;

  logic        PCLK = 1'b0, PRESETN = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [7:0]  PADDR = 8'h00;
  logic [31:0] PWDATA = 32'd0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, IRQ;
  logic [7:0]  GPIO_D, GPIO_E, GPIO_Y;
  logic [7:0]  y_ext = 8'hFF;

  // Pad cell model: a driven pin reads back its own D.
  assign GPIO_Y = (GPIO_E & GPIO_D) | (~GPIO_E & y_ext);

  gpio_pad_ctrl #(.NUM_PINS(8), .DOUT_RESET(32'd0), .OE_RESET(32'd0)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .GPIO_D(GPIO_D), .GPIO_E(GPIO_E),
    .GPIO_Y(GPIO_Y), .IRQ(IRQ)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    bit          ci;   // check IRQ at access
    logic        irq;
    bit          cp;   // check pins at access
    bit          cpn;  // check pins one cycle after access (write landed)
    logic [7:0]  gd;
    logic [7:0]  ge;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   passed = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", n, act, want);
  endtask

  function automatic exp_t mk(input string n, input logic [31:0] rd, input logic err);
    exp_t x;
    x.name = n; x.rdata = rd; x.err = err; x.ci = 0; x.irq = 0;
    x.cp = 0; x.cpn = 0; x.gd = 8'h00; x.ge = 8'h00;
    return x;
  endfunction

  function automatic exp_t mki(input string n, input logic [31:0] rd, input logic irq);
    exp_t x;
    x = mk(n, rd, 1'b0);
    x.ci = 1; x.irq = irq;
    return x;
  endfunction

  // Monitor
  exp_t cur, pe;
  bit   pend = 0;
  always @(negedge PCLK) begin
    if (pend) begin
      chk({pe.name, "_gpio_d"}, {24'd0, GPIO_D}, {24'd0, pe.gd});
      chk({pe.name, "_gpio_e"}, {24'd0, GPIO_E}, {24'd0, pe.ge});
      pend = 0;
    end
    if (PSEL && PENABLE) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_access: addr 0x%0h, got no expectation, want one", PADDR);
      end else begin
        cur = exp_q.pop_front();
        chk({cur.name, "_prdata"}, PRDATA, cur.rdata);
        chk({cur.name, "_pslverr"}, {31'd0, PSLVERR}, {31'd0, cur.err});
        chk({cur.name, "_pready"}, {31'd0, PREADY}, 32'd1);
        if (cur.ci) chk({cur.name, "_irq"}, {31'd0, IRQ}, {31'd0, cur.irq});
        if (cur.cp) begin
          chk({cur.name, "_gpio_d"}, {24'd0, GPIO_D}, {24'd0, cur.gd});
          chk({cur.name, "_gpio_e"}, {24'd0, GPIO_E}, {24'd0, cur.ge});
        end
        if (cur.cpn) begin pe = cur; pend = 1; end
      end
    end
  end

  task automatic xfer(input bit w, input logic [7:0] a, input logic [31:0] d, input exp_t x);
    @(posedge PCLK); #1;
    exp_q.push_back(x);
    PSEL = 1; PENABLE = 0; PWRITE = w; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1 PENABLE = 1;
    @(posedge PCLK); #1 PSEL = 0; PENABLE = 0;
  endtask

  // Change the pad at edge N, then run an access whose access phase follows
  // edge N+lat (a write therefore lands on edge N+lat+1).
  task automatic probe(input bit w, input logic [7:0] a, input logic [31:0] d,
                       input logic [7:0] y, input int lat, input exp_t x);
    @(posedge PCLK); #1 y_ext = y;
    repeat (lat - 1) begin @(posedge PCLK); #1; end
    exp_q.push_back(x);
    PSEL = 1; PENABLE = 0; PWRITE = w; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1 PENABLE = 1;
    @(posedge PCLK); #1 PSEL = 0; PENABLE = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    exp_t x;
    // Reset with all pads high; first write to RISE_EN begins on the release
    // edge so its enable is live while the synchroniser is still filling.
    repeat (4) @(posedge PCLK);
    #1 PRESETN = 1;
    x = mki("arm_wr_rise_en", 0, 0); x.cp = 1;
    exp_q.push_back(x);
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 8'h0C; PWDATA = 32'hFF;
    @(posedge PCLK); #1 PENABLE = 1;
    @(posedge PCLK); #1 PSEL = 0; PENABLE = 0;

    x = mk("rst_data_out", 0, 0); x.cp = 1; xfer(0, 8'h00, 0, x);
    xfer(0, 8'h04, 0, mk("rst_oe", 0, 0));
    xfer(0, 8'h14, 0, mki("arm_no_spurious", 0, 0));
    xfer(0, 8'h0C, 0, mk("rise_en_rb", 32'hFF, 0));
    xfer(0, 8'h08, 0, mk("din_all_high", 32'hFF, 0));

    // Output drive and loopback
    x = mk("wr_dout", 0, 0); x.cpn = 1; x.gd = 8'hA5; x.ge = 8'h00;
    xfer(1, 8'h00, 32'hA5, x);
    x = mk("wr_oe", 0, 0); x.cpn = 1; x.gd = 8'hA5; x.ge = 8'h0F;
    xfer(1, 8'h04, 32'h0F, x);
    xfer(0, 8'h00, 0, mk("dout_rb", 32'hA5, 0));
    xfer(0, 8'h04, 0, mk("oe_rb", 32'h0F, 0));
    xfer(0, 8'h08, 0, mk("loopback_din", 32'hF5, 0));
    xfer(1, 8'h0C, 32'h00, mk("rise_en_off", 0, 0));
    x = mk("oe_off", 0, 0); x.cpn = 1; x.gd = 8'hA5; x.ge = 8'h00;
    xfer(1, 8'h04, 32'h00, x);

    // Input synchroniser latency
    @(posedge PCLK); #1 y_ext = 8'h00;
    repeat (4) @(posedge PCLK);
    probe(0, 8'h08, 0, 8'h3C, 1, mk("din_at_n1", 32'h00, 0));
    @(posedge PCLK); #1 y_ext = 8'h00;
    repeat (4) @(posedge PCLK);
    probe(0, 8'h08, 0, 8'h3C, 2, mk("din_at_n2", 32'h3C, 0));

    // Edge interrupts
    xfer(1, 8'h0C, 32'h01, mk("wr_rise_en", 0, 0));
    xfer(1, 8'h10, 32'h02, mk("wr_fall_en", 0, 0));
    probe(0, 8'h14, 0, 8'h3D, 2, mki("st_before_n3", 0, 0));
    xfer(0, 8'h14, 0, mki("st_pin0_rise", 32'h01, 1));
    @(posedge PCLK); #1 y_ext = 8'h3C;
    repeat (3) @(posedge PCLK); #1 y_ext = 8'h3E;
    repeat (3) @(posedge PCLK); #1 y_ext = 8'h3C;
    repeat (4) @(posedge PCLK);
    xfer(0, 8'h14, 0, mki("st_both", 32'h03, 1));
    xfer(1, 8'h14, 32'h01, mk("w1c_bit0", 0, 0));
    xfer(0, 8'h14, 0, mki("st_after_w1c0", 32'h02, 1));
    xfer(1, 8'h14, 32'h02, mk("w1c_bit1", 0, 0));
    xfer(0, 8'h14, 0, mki("st_cleared", 32'h00, 0));

    // W1C colliding with a new edge on the same bit
    xfer(1, 8'h0C, 32'h04, mk("wr_rise_en2", 0, 0));
    @(posedge PCLK); #1 y_ext = 8'h38;
    repeat (4) @(posedge PCLK);
    probe(1, 8'h14, 32'h04, 8'h3C, 2, mk("w1c_collide", 0, 0));
    xfer(0, 8'h14, 0, mki("collide_set_wins", 32'h04, 1));
    xfer(1, 8'h0C, 32'h00, mk("rise_en_disable", 0, 0));
    xfer(0, 8'h14, 0, mki("st_kept_disabled", 32'h04, 1));
    xfer(1, 8'h14, 32'h04, mk("w1c_bit2", 0, 0));
    xfer(0, 8'h14, 0, mki("st_cleared2", 32'h00, 0));

    // Unmapped and read-only addresses
    xfer(0, 8'h20, 0, mk("rd_unmapped", 32'h0, 1));
    xfer(1, 8'h18, 32'hFF, mk("wr_unmapped", 0, 1));
    xfer(1, 8'h08, 32'hFF, mk("wr_din_ro", 0, 0));
    xfer(0, 8'h00, 0, mk("dout_unchanged", 32'hA5, 0));
    xfer(0, 8'h03, 0, mk("addr_lsb_ignored", 32'hA5, 0));
    xfer(0, 8'h04, 0, mk("oe_unchanged", 32'h00, 0));
    xfer(0, 8'h0C, 0, mk("ren_unchanged", 32'h00, 0));
    xfer(0, 8'h10, 0, mk("fen_unchanged", 32'h02, 0));
    xfer(0, 8'h14, 0, mki("st_unchanged", 32'h00, 0));

    // Reset lands on a write access phase: write aborted
    @(posedge PCLK); #1;
    x = mk("rst_abort", 0, 0); x.cpn = 1; x.gd = 8'h00; x.ge = 8'h00;
    exp_q.push_back(x);
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 8'h00; PWDATA = 32'h77;
    @(posedge PCLK); #1 PENABLE = 1; PRESETN = 0;
    @(posedge PCLK); #1 PSEL = 0; PENABLE = 0;
    @(posedge PCLK); #1 PRESETN = 1;
    xfer(0, 8'h00, 0, mk("dout_after_abort", 32'h00, 0));
    xfer(0, 8'h10, 0, mk("fen_after_reset", 32'h00, 0));

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge PCLK);
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    repeat (2) @(posedge PCLK);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gpio_pad_ctrl.md
Name: gpio_pad_ctrl

Overview:
APB3 GPIO controller that sits on the fabric side of an array of single-ended bidirectional pad cells. Per pin it drives output data (D) and output enable (E), and samples the pad input (Y). It synchronises inputs, detects per-pin rising/falling edges, and raises a level interrupt to the MIV core. It is the register-mapped master of the pad cells' D/E/Y interface.

Parameters:
NUM_PINS, 8, number of GPIO pins (1..32); register bits at or above NUM_PINS read 0 and ignore writes.
DOUT_RESET, 0, reset value of the DATA_OUT register.
OE_RESET, 0, reset value of the OE register (0 = all pins input / tristate).

Ports:
PCLK  in  1  system clock; all logic is on the rising edge.
PRESETN  in  1  reset, synchronous, active-low.
PSEL  in  1  APB select.
PENABLE  in  1  APB access phase.
PWRITE  in  1  1 = write, 0 = read.
PADDR  in  8  byte address; bits [1:0] are ignored.
PWDATA  in  32  write data.
PRDATA  out  32  read data.
PREADY  out  1  constant 1 (zero wait states).
PSLVERR  out  1  error response for unmapped address.
GPIO_D  out  NUM_PINS  to pad cell D inputs.
GPIO_E  out  NUM_PINS  to pad cell E inputs (1 = drive).
GPIO_Y  in  NUM_PINS  from pad cell Y outputs; asynchronous to PCLK.
IRQ  out  1  level interrupt, active-high.

Behaviour:
- Reset: PRESETN low at a PCLK edge sets DATA_OUT=DOUT_RESET, OE=OE_RESET, RISE_EN=0, FALL_EN=0, STATUS=0, sync flops=0, arm counter=0. Outputs during reset: GPIO_D=DOUT_RESET, GPIO_E=OE_RESET, IRQ=0, PRDATA=0, PSLVERR=0, PREADY=1. Reset asserted mid-transfer aborts the transfer with no register update.
- Register map: 0x00 DATA_OUT RW; 0x04 OE RW; 0x08 DATA_IN RO (synchronised pins); 0x0C RISE_EN RW; 0x10 FALL_EN RW; 0x14 STATUS RW1C.
- Write: takes effect at the PCLK edge where PSEL&PENABLE&PWRITE; GPIO_D/GPIO_E update in the same edge (0 cycles after the access phase). A write to DATA_IN is ignored with PSLVERR=0.
- Read: PRDATA is combinational, valid while PSEL&PENABLE&!PWRITE, and is 0 otherwise.
- Unmapped address (above 0x14): PSLVERR=1 during the access phase; reads return 0; writes have no effect.
- Input path: 2-flop synchroniser (s1, s2) plus history flop s3. DATA_IN=s2, so a pad change is visible in DATA_IN 2 edges later.
- Edge detect:
  - rise[i] = s2[i] & ~s3[i] & RISE_EN[i]
  - fall[i] = ~s2[i] & s3[i] & FALL_EN[i]
  - A detected edge sets STATUS[i] at the next edge, i.e. 3 edges after the pad change.
- Arming: edge detection is suppressed until 3 edges after PRESETN deasserts (2-bit saturating counter), so pins held high at reset do not flag spurious edges.
- STATUS clear: writing 1 to a bit clears it; writing 0 leaves it unchanged. If a W1C and a new edge on the same bit occur in the same cycle, the set wins (STATUS stays 1).
- Enable changes: disabling RISE_EN/FALL_EN does not clear existing STATUS bits.
- IRQ = |(STATUS), registered as the STATUS flops themselves drive it; no extra latency. IRQ stays 1 until every set bit is cleared.
- Loopback: with OE[i]=1, GPIO_Y[i] follows GPIO_D[i] through the pad cell, so DATA_IN shows the driven value and self-driven edges are detected.
- Pin count: bits at or above NUM_PINS are tied 0 in all registers and in PRDATA.

Test Plan:
- Reset values: hold PRESETN low 4 cycles with GPIO_Y=0xFF, then release. Read 0x00/0x04/0x14 -> 0/0/0, IRQ=0. With RISE_EN written 0xFF after release -> STATUS remains 0, no spurious edge.
- Output drive: write 0xA5 to 0x00 and 0x0F to 0x04 -> GPIO_D=0xA5, GPIO_E=0x0F on the access-phase edge. Read back 0xA5 and 0x0F.
- Input sync latency: GPIO_Y toggles 0x00->0x3C at edge N -> DATA_IN reads 0x00 through edge N+1, and reads 0x3C from edge N+2.
- Edge interrupts:
  - RISE_EN=0x01, FALL_EN=0x02; pulse pin0 high, then pin1 low->high->low.
  - STATUS=0x03 (pin0 at pad-change+3 edges); IRQ=1.
  - Write 0x01 to 0x14 -> STATUS=0x02, IRQ=1. Write 0x02 -> IRQ=0.
- W1C/set collision: a rising edge on pin2 lands in the same cycle as a W1C of bit 2 -> STATUS[2]=1, IRQ=1.
- Error and reset mid-op:
  - Read 0x20 -> PRDATA=0, PSLVERR=1.
  - Write 0x18 -> no register changes.
  - Assert PRESETN during a write access phase to 0x00 -> DATA_OUT=DOUT_RESET afterwards.
